// File: rtl/history_pkg.sv
// Shared definitions for the transaction history log: FSM encoding,
// channel-count log2 and the {channel, tid} entry address layout.
package history_pkg;

    // Sweep/run state encoding (kept as plain constants for legacy users)
    localparam logic S_CLEAR = 1'b0;
    localparam logic S_RUN   = 1'b1;

    // Number of bits needed to index n channels (ceil(log2(n)), minimum 0)
    function automatic int unsigned ch_log2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Entry address: channel in the MSBs, TID in the LSBs
    function automatic int unsigned entry_addr(input int unsigned ch,
                                               input int unsigned tid,
                                               input int unsigned tid_w);
        return (ch << tid_w) | tid;
    endfunction

endpackage

// File: rtl/hist_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner when advanced.
module hist_rr_arb
    import history_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned W = ch_log2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_adv,
    output logic [N-1:0] o_gnt
);

    logic [W-1:0] r_ptr;
    logic [W-1:0] w_cand;
    logic [W-1:0] w_idx;
    logic         w_found;

    // Scan requesters starting at the pointer; N is a power of two so the
    // candidate index wraps naturally.
    always_comb begin
        o_gnt   = '0;
        w_cand  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = r_ptr + W'(k);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        if (w_found) begin
            o_gnt[w_idx] = 1'b1;
        end
    end

    // Pointer moves to winner+1 on a grant, holds otherwise
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_adv && w_found) begin
            r_ptr <= w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/history_log.sv
// Multi-channel transaction history memory: one region of 2^TID_W words per
// write channel in a single inferred dual-port RAM, round-robin write
// arbitration, clear sweep after reset/on request, freeze with drop counter.
module history_log
    import history_pkg::*;
#(
    parameter int          TCQ     = 100,
    parameter int unsigned DATA_W  = 36,
    parameter int unsigned TID_W   = 8,
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned OUT_REG = 0,
    localparam int unsigned CH_W   = ch_log2(NUM_CH)
) (
    input  logic                     lnk_clk,
    input  logic                     lnk_reset_n,
    input  logic [NUM_CH-1:0]        wr_valid,
    output logic [NUM_CH-1:0]        wr_ready,
    input  logic [NUM_CH*TID_W-1:0]  wr_tid,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic                     rd_req,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic [TID_W-1:0]         rd_tid,
    output logic                     rd_gnt,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     clear_req,
    input  logic                     freeze,
    output logic                     busy,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned AW    = CH_W + TID_W;
    localparam int unsigned DEPTH = 1 << AW;

    if (NUM_CH < 2 || NUM_CH > 8 || (NUM_CH & (NUM_CH - 1)) != 0 ||
        TCQ < 0 || OUT_REG > 1) begin : g_param_err
        $error("history_log: unsupported parameter set");
    end

    logic                r_state;
    logic [AW-1:0]       r_clr_cnt;
    logic [15:0]         r_drop_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd_q;
    logic                r_rd_vld;

    logic                w_run;
    logic                w_wr_en;
    logic [NUM_CH-1:0]   w_arb_req;
    logic [NUM_CH-1:0]   w_gnt;
    logic                w_we;
    logic [AW-1:0]       w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [CH_W-1:0]     w_wch;
    logic [TID_W-1:0]    w_wtid;
    logic [DATA_W-1:0]   w_wdat;
    logic [AW-1:0]       w_raddr;
    logic [3:0]          w_drop_inc;
    logic [16:0]         w_drop_sum;

    assign w_run     = (r_state == S_RUN);
    assign w_wr_en   = w_run && !freeze;
    assign w_arb_req = w_wr_en ? wr_valid : '0;
    assign busy      = !w_run;
    assign rd_gnt    = w_run && rd_req;
    assign drop_cnt  = r_drop_cnt;
    assign w_raddr   = AW'(entry_addr(32'(rd_ch), 32'(rd_tid), TID_W));

    hist_rr_arb #(
        .N(NUM_CH)
    ) u_arb (
        .i_clk   (lnk_clk),
        .i_rst_n (lnk_reset_n),
        .i_req   (w_arb_req),
        .i_adv   (w_wr_en),
        .o_gnt   (w_gnt)
    );

    // Frozen writes are all accepted (and discarded); otherwise the arbiter decides
    always_comb begin
        if (!w_run) begin
            wr_ready = '0;
        end else if (freeze) begin
            wr_ready = wr_valid;
        end else begin
            wr_ready = w_gnt;
        end
    end

    // Write port source: zero sweep while clearing, granted channel while running
    always_comb begin
        w_wch  = '0;
        w_wtid = '0;
        w_wdat = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_gnt[c]) begin
                w_wch  = CH_W'(c);
                w_wtid = wr_tid[c*TID_W +: TID_W];
                w_wdat = wr_data[c*DATA_W +: DATA_W];
            end
        end
        if (!w_run) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wdata = '0;
        end else begin
            w_we    = |w_gnt;
            w_waddr = AW'(entry_addr(32'(w_wch), 32'(w_wtid), TID_W));
            w_wdata = w_wdat;
        end
    end

    // Number of writes discarded this cycle while frozen
    always_comb begin
        w_drop_inc = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_drop_inc = w_drop_inc + {3'b000, wr_valid[c]};
        end
        w_drop_sum = {1'b0, r_drop_cnt} + {13'b0, w_drop_inc};
    end

    // Sweep/run state and clear address counter
    always_ff @(posedge lnk_clk) begin
        if (!lnk_reset_n) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == '1) begin
                r_state <= S_RUN;
            end
        end else if (clear_req) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end
    end

    // Saturating drop counter, cleared only by reset
    always_ff @(posedge lnk_clk) begin
        if (!lnk_reset_n) begin
            r_drop_cnt <= '0;
        end else if (w_run && freeze) begin
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    // RAM write port
    always_ff @(posedge lnk_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // RAM read port, read-first against a same-cycle write
    always_ff @(posedge lnk_clk) begin
        if (!lnk_reset_n) begin
            r_rd_q   <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= rd_gnt;
            if (rd_gnt) begin
                r_rd_q <= r_mem[w_raddr];
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              r_vld2;
        logic [DATA_W-1:0] r_dat2;

        // Optional output stage adding one cycle of read latency
        always_ff @(posedge lnk_clk) begin
            if (!lnk_reset_n) begin
                r_vld2 <= 1'b0;
                r_dat2 <= '0;
            end else begin
                r_vld2 <= r_rd_vld;
                if (r_rd_vld) begin
                    r_dat2 <= r_rd_q;
                end
            end
        end

        assign rd_valid = r_vld2;
        assign rd_data  = r_dat2;
    end else begin : g_noreg
        assign rd_valid = r_rd_vld;
        assign rd_data  = r_rd_q;
    end

endmodule

// File: tb/tb_history_log.sv
// Bench for history_log: default configuration checked every cycle against a
// behavioural model, plus a NUM_CH=4/OUT_REG=1 instance for latency/sweep length.
module tb_history_log;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [1:0]   wr_valid, wr_ready;
    logic [15:0]  wr_tid;
    logic [71:0]  wr_data;
    logic         rd_req, rd_ch, rd_gnt, rd_valid;
    logic [7:0]   rd_tid;
    logic [35:0]  rd_data;
    logic         clear_req, freeze, busy;
    logic [15:0]  drop_cnt;

    logic [3:0]   wr_valid4, wr_ready4;
    logic [31:0]  wr_tid4;
    logic [143:0] wr_data4;
    logic         rd_req4, rd_gnt4, rd_valid4;
    logic [1:0]   rd_ch4;
    logic [7:0]   rd_tid4;
    logic [35:0]  rd_data4;
    logic         clear_req4, freeze4, busy4;
    logic [15:0]  drop_cnt4;

    int checks = 0;
    int errors = 0;

    history_log u_dut (
        .lnk_clk(clk), .lnk_reset_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_tid(wr_tid), .wr_data(wr_data),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_tid(rd_tid), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .clear_req(clear_req), .freeze(freeze), .busy(busy), .drop_cnt(drop_cnt)
    );

    history_log #(.NUM_CH(4), .OUT_REG(1)) u_dut4 (
        .lnk_clk(clk), .lnk_reset_n(rst_n),
        .wr_valid(wr_valid4), .wr_ready(wr_ready4), .wr_tid(wr_tid4), .wr_data(wr_data4),
        .rd_req(rd_req4), .rd_ch(rd_ch4), .rd_tid(rd_tid4), .rd_gnt(rd_gnt4),
        .rd_valid(rd_valid4), .rd_data(rd_data4),
        .clear_req(clear_req4), .freeze(freeze4), .busy(busy4), .drop_cnt(drop_cnt4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the default instance ----------------
    bit          m_live = 1'b0;
    int          m_sweep, m_ptr, m_drop, pc, cc;
    logic        m_vld;
    logic [35:0] m_data;
    logic [35:0] m_mem [2][256];
    logic [1:0]  e_rdy;
    logic        e_gnt, e_busy;

    task automatic clear_mem();
        for (int c = 0; c < 2; c++)
            for (int t = 0; t < 256; t++)
                m_mem[c][t] = '0;
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            e_busy = (m_sweep > 0);
            e_gnt  = !e_busy && rd_req;
            e_rdy  = '0;
            if (!e_busy) begin
                if (freeze) e_rdy = wr_valid;
                else begin
                    for (int k = 0; k < 2; k++) begin
                        cc = (m_ptr + k) % 2;
                        if (e_rdy == 2'b00 && wr_valid[cc]) e_rdy[cc] = 1'b1;
                    end
                end
            end
            check("busy", busy, e_busy);
            check("wr_ready", wr_ready, e_rdy);
            check("rd_gnt", rd_gnt, e_gnt);
            check("rd_valid", rd_valid, m_vld);
            check("rd_data", rd_data, m_data);
            check("drop_cnt", drop_cnt, m_drop);
        end
        if (!rst_n) begin
            m_live  = 1'b1;
            m_sweep = 512;
            m_ptr   = 0;
            m_drop  = 0;
            m_vld   = 1'b0;
            m_data  = '0;
            clear_mem();
        end else if (m_live) begin
            if (m_sweep > 0) begin
                m_sweep--;
                m_vld = 1'b0;
            end else begin
                m_vld = rd_req;
                if (rd_req) m_data = m_mem[rd_ch][rd_tid];
                if (freeze) begin
                    pc = int'(wr_valid[0]) + int'(wr_valid[1]);
                    m_drop = (m_drop + pc > 65535) ? 65535 : m_drop + pc;
                end else begin
                    for (int c = 0; c < 2; c++) begin
                        if (e_rdy[c]) begin
                            m_mem[c][wr_tid[c*8 +: 8]] = wr_data[c*36 +: 36];
                            m_ptr = (c + 1) % 2;
                        end
                    end
                end
                if (clear_req) begin
                    m_sweep = 512;
                    clear_mem();
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr0(input logic [1:0] v, input logic [7:0] t0, input logic [7:0] t1,
                       input logic [35:0] d0, input logic [35:0] d1);
        wr_valid = v;
        wr_tid   = {t1, t0};
        wr_data  = {d1, d0};
    endtask

    task automatic rd0(input logic ch, input logic [7:0] tid, input logic [35:0] exp,
                       input string nm);
        rd_req = 1'b1;
        rd_ch  = ch;
        rd_tid = tid;
        #1;
        check({nm, " gnt"}, rd_gnt, 1'b1);
        tick();
        rd_req = 1'b0;
        #1;
        check({nm, " valid"}, rd_valid, 1'b1);
        check(nm, rd_data, exp);
    endtask

    int n, t0, t4;
    logic [1:0] cont_seq [7] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [1:0] frz_seq  [3] = '{2'b01, 2'b10, 2'b01};

    initial begin
        rst_n = 1'b0;
        wr_valid = '0; wr_tid = '0; wr_data = '0;
        rd_req = 1'b0; rd_ch = 1'b0; rd_tid = '0;
        clear_req = 1'b0; freeze = 1'b0;
        wr_valid4 = '0; wr_tid4 = '0; wr_data4 = '0;
        rd_req4 = 1'b0; rd_ch4 = '0; rd_tid4 = '0;
        clear_req4 = 1'b0; freeze4 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check("reset busy", busy, 1'b1);
        check("reset busy4", busy4, 1'b1);
        check("reset drop_cnt", drop_cnt, 16'h0);
        check("reset rd_valid", rd_valid, 1'b0);

        // Sweep length for both instances; requests during the sweep are held off
        wr_valid = 2'b01;
        rd_req   = 1'b1;
        n = 0; t0 = -1; t4 = -1;
        while ((busy || busy4) && n < 1200) begin
            if (n == 10) begin
                wr_valid = '0;
                rd_req   = 1'b0;
            end
            tick();
            n++;
            if (!busy && t0 < 0) t0 = n;
            if (!busy4 && t4 < 0) t4 = n;
        end
        check("sweep cycles ch2", t0, 512);
        check("sweep cycles ch4", t4, 1024);

        // Read of a cleared entry
        rd0(1'b1, 8'h7F, 36'h0, "idle rd ch1 7F");

        // OUT_REG=1: two-cycle read latency
        rd_req4 = 1'b1; rd_ch4 = 2'd3; rd_tid4 = 8'hFF;
        #1;
        check("ch4 gnt", rd_gnt4, 1'b1);
        tick();
        rd_req4 = 1'b0;
        #1;
        check("ch4 valid +1", rd_valid4, 1'b0);
        tick();
        #1;
        check("ch4 valid +2", rd_valid4, 1'b1);
        check("ch4 data", rd_data4, 36'h0);
        check("ch4 drop_cnt", drop_cnt4, 16'h0);

        // Write and readback from separate regions
        wr0(2'b01, 8'h05, 8'h00, 36'h9_ABCD_1234, 36'h0);
        #1;
        check("wr ch0 ready", wr_ready, 2'b01);
        tick();
        wr0(2'b10, 8'h00, 8'h05, 36'h0, 36'h1_0000_0001);
        #1;
        check("wr ch1 ready", wr_ready, 2'b10);
        tick();
        wr_valid = '0;
        rd0(1'b0, 8'h05, 36'h9_ABCD_1234, "rd ch0 05");
        rd0(1'b1, 8'h05, 36'h1_0000_0001, "rd ch1 05");

        // Read-first on a same-cycle write to the same entry
        wr0(2'b10, 8'h00, 8'h05, 36'h0, 36'h2_2222_3333);
        rd0(1'b1, 8'h05, 36'h1_0000_0001, "read-first");
        wr_valid = '0;
        rd0(1'b1, 8'h05, 36'h2_2222_3333, "rd after wr");

        // Contention: alternate while both request, then ch1 alone
        for (int i = 0; i < 7; i++) begin
            wr0((i < 4) ? 2'b11 : 2'b10, 8'h10, 8'h20,
                36'h0_AAAA_0000 + 36'(i), 36'h0_BBBB_0000 + 36'(i));
            #1;
            check("contention ready", wr_ready, cont_seq[i]);
            tick();
        end
        wr_valid = '0;
        rd0(1'b0, 8'h10, 36'h0_AAAA_0002, "rd ch0 10");
        rd0(1'b1, 8'h20, 36'h0_BBBB_0006, "rd ch1 20");

        // Freeze: writes accepted and discarded
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr0(frz_seq[i], 8'h05, 8'h05, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF);
            #1;
            check("freeze ready", wr_ready, frz_seq[i]);
            tick();
        end
        wr_valid = '0;
        freeze = 1'b0;
        #1;
        check("drop_cnt 3", drop_cnt, 16'd3);
        rd0(1'b0, 8'h05, 36'h9_ABCD_1234, "frozen ch0 unchanged");
        rd0(1'b1, 8'h05, 36'h2_2222_3333, "frozen ch1 unchanged");

        // Saturation: pump to FFFE, then 3 more drops
        freeze = 1'b1;
        wr_valid = 2'b01;
        tick();
        wr_valid = 2'b11;
        repeat (32765) tick();
        wr_valid = '0;
        #1;
        check("drop_cnt FFFE", drop_cnt, 16'hFFFE);
        wr_valid = 2'b11;
        tick();
        wr_valid = 2'b01;
        tick();
        wr_valid = '0;
        freeze = 1'b0;
        #1;
        check("drop_cnt sat", drop_cnt, 16'hFFFF);

        // clear_req mid-sweep is ignored
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        #1;
        check("clear busy", busy, 1'b1);
        n = 0;
        while (busy && n < 1100) begin
            if (n == 200) clear_req = 1'b1;
            tick();
            clear_req = 1'b0;
            n++;
        end
        check("clear sweep cycles", n, 512);
        check("drop kept over clear", drop_cnt, 16'hFFFF);
        rd0(1'b0, 8'h05, 36'h0, "rd after clear");

        // Reset mid-sweep restarts from address 0
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (300) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("reset drop_cnt 0", drop_cnt, 16'h0);
        n = 0;
        while (busy && n < 1100) begin
            tick();
            n++;
        end
        check("restart sweep cycles", n, 512);
        rd0(1'b1, 8'h05, 36'h0, "rd after reset");

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
